// File: rtl/tape_rec_uart.sv
// Cassette recorder path: measures tape_out half-periods while the motor runs,
// queues one byte per half-period and streams the bytes out as 8N1 serial.
module tape_rec_uart #(
   parameter int TICK_DIV = 640,
   parameter int BAUD_DIV = 556,
   parameter int FIFO_AW  = 4
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               tape_out,
   input  logic               tape_motor,
   output logic               uart_tx,
   output logic               busy,
   output logic               overrun,
   output logic [FIFO_AW:0]   fifo_level
);
   localparam int PW    = $clog2(TICK_DIV + 1);
   localparam int BW    = $clog2(BAUD_DIV + 1);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [1:0]         tape_sync_q, motor_sync_q;
   logic               tape_dly_q;
   logic               tape_s, motor_s, edge_w, tick;
   logic [PW-1:0]      pre_q, pre_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               armed_q, armed_d;
   logic               push_q, push_d;
   logic [7:0]         pdata_q, pdata_d;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_q, rd_q;
   logic [FIFO_AW:0]   level_q;
   logic               overrun_q, full, pop, wr_en;
   state_t             state_q, state_d;
   logic [BW-1:0]      baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         sh_q, sh_d;
   logic               baud_end, tx;

   assign tape_s  = tape_sync_q[1];
   assign motor_s = motor_sync_q[1];
   assign edge_w  = tape_s ^ tape_dly_q;
   assign tick    = (pre_q == PW'(TICK_DIV - 1));

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tape_sync_q  <= '0;
         motor_sync_q <= '0;
         tape_dly_q   <= 1'b0;
      end else begin
         tape_sync_q  <= {tape_sync_q[0], tape_out};
         motor_sync_q <= {motor_sync_q[0], tape_motor};
         tape_dly_q   <= tape_s;
      end
   end

   // An edge takes priority over a coincident overflow tick: its width byte is pushed instead of 0x00.
   always_comb begin
      pre_d   = pre_q + 1'b1;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      push_d  = 1'b0;
      pdata_d = cnt_q;
      if (!motor_s) begin
         pre_d   = '0;
         cnt_d   = '0;
         armed_d = 1'b0;
      end else if (edge_w) begin
         pre_d   = '0;
         cnt_d   = '0;
         armed_d = 1'b1;
         push_d  = armed_q;
         pdata_d = (cnt_q == 8'd0) ? 8'd1 : cnt_q;
      end else if (tick) begin
         pre_d = '0;
         cnt_d = cnt_q + 8'd1;
         if (armed_q && cnt_q == 8'hFF) begin
            push_d  = 1'b1;
            pdata_d = 8'h00;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pre_q   <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         push_q  <= 1'b0;
         pdata_q <= '0;
      end else begin
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         push_q  <= push_d;
         pdata_q <= pdata_d;
      end
   end

   assign full  = (level_q == (FIFO_AW+1)'(DEPTH));
   assign pop   = (state_q == IDLE) && (level_q != '0);
   assign wr_en = push_q && (!full || pop);

   always_ff @(posedge clk_sys) begin
      if (wr_en) mem[wr_q] <= pdata_q;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_q      <= '0;
         rd_q      <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (pop)   rd_q <= rd_q + 1'b1;
         case ({wr_en, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
         if (push_q && full && !pop) overrun_q <= 1'b1;
      end
   end

   assign baud_end = (baud_q == BW'(BAUD_DIV - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      tx      = 1'b1;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (level_q != '0) begin
               sh_d    = mem[rd_q];
               state_d = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            tx = sh_q[bit_q];
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   assign uart_tx    = tx;
   assign busy       = (level_q != '0) || (state_q != IDLE);
   assign overrun    = overrun_q;
   assign fifo_level = level_q;
endmodule

// File: tb/tb_tape_rec_uart.sv
// Directed bench: width vectors from a table, then motor gating, overrun and reset corner cases.
module tb_tape_rec_uart;
   localparam int T = 4;
   localparam int B = 16;

   logic       clk, reset, tape_out, tape_motor;
   logic       uart_tx, busy, overrun;
   logic [4:0] fifo_level;

   tape_rec_uart #(.TICK_DIV(T), .BAUD_DIV(B), .FIFO_AW(4)) dut (
      .clk_sys(clk), .reset(reset), .tape_out(tape_out), .tape_motor(tape_motor),
      .uart_tx(uart_tx), .busy(busy), .overrun(overrun), .fifo_level(fifo_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int passed = 0;
   int total  = 0;
   int ferr   = 0;
   logic [7:0] rx_q[$];
   logic [7:0] rb;

   // Serial receiver: samples the middle of each bit.
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && uart_tx === 1'b0) begin
            repeat (B/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (B) @(negedge clk);
               rb[i] = uart_tx;
            end
            repeat (B) @(negedge clk);
            if (uart_tx !== 1'b1) ferr++;
            rx_q.push_back(rb);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input int n);
      for (int c = 0; c < 3000 && !(rx_q.size() >= n && !busy); c++) @(negedge clk);
   endtask

   // gap in clk cycles between the arming edge and the measured edge; bytes listed low first
   typedef struct packed {
      int          gap;
      int          n;
      logic [23:0] exp;
   } vec_t;

   vec_t vt [8];
   logic busy_seen;

   initial begin
      vt[0] = '{50*T+2,  1, 24'h000032};
      vt[1] = '{30*T+2,  1, 24'h00001E};
      vt[2] = '{600*T+2, 3, 24'h580000};
      vt[3] = '{1,       1, 24'h000001};
      vt[4] = '{256*T,   1, 24'h0000FF};
      vt[5] = '{255*T+2, 1, 24'h0000FF};
      vt[6] = '{256*T+2, 2, 24'h000100};
      vt[7] = '{2*T+2,   1, 24'h000002};

      reset = 1'b1; tape_out = 1'b0; tape_motor = 1'b0;
      cyc(4);
      chk("rst_tx", uart_tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_level", fifo_level, 0);
      reset = 1'b0;
      cyc(3);

      for (int v = 0; v < 8; v++) begin
         rx_q.delete();
         tape_motor = 1'b1;
         cyc(6);
         tape_out = ~tape_out;
         cyc(vt[v].gap);
         tape_out = ~tape_out;
         drain(vt[v].n);
         chk($sformatf("vec%0d_count", v), rx_q.size(), vt[v].n);
         for (int k = 0; k < vt[v].n && k < rx_q.size(); k++)
            chk($sformatf("vec%0d_byte%0d", v, k), rx_q[k], vt[v].exp[8*k +: 8]);
         chk($sformatf("vec%0d_idle", v), busy, 0);
         tape_motor = 1'b0;
         cyc(4);
      end

      // motor off: edges are ignored
      rx_q.delete();
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tape_out = ~tape_out;
         cyc(3);
         if (busy !== 1'b0) busy_seen = 1'b1;
      end
      cyc(40);
      chk("gate_busy", busy_seen, 0);
      chk("gate_level", fifo_level, 0);
      chk("gate_rx", rx_q.size(), 0);

      // queue three bytes, then stop the motor: the queue still drains
      tape_motor = 1'b1;
      cyc(6);
      tape_out = ~tape_out;
      for (int i = 0; i < 3; i++) begin
         cyc(5*T+2);
         tape_out = ~tape_out;
      end
      cyc(5);
      tape_motor = 1'b0;
      cyc(4);
      chk("moff_level", fifo_level, 2);
      chk("moff_busy", busy, 1);
      drain(3);
      chk("moff_count", rx_q.size(), 3);
      for (int k = 0; k < 3 && k < rx_q.size(); k++)
         chk($sformatf("moff_byte%0d", k), rx_q[k], 8'h05);
      chk("moff_idle", busy, 0);
      chk("frame_err", ferr, 0);

      // 20 edges far faster than the link drains
      rx_q.delete();
      tape_motor = 1'b1;
      cyc(6);
      tape_out = ~tape_out;
      for (int i = 0; i < 19; i++) begin
         cyc(2*T);
         tape_out = ~tape_out;
      end
      cyc(6);
      chk("ovr_level", fifo_level, 16);
      chk("ovr_flag", overrun, 1);
      chk("ovr_busy", busy, 1);

      // reset in the middle of a frame
      for (int c = 0; c < 200 && uart_tx !== 1'b0; c++) @(negedge clk);
      chk("mid_frame_low", uart_tx, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst2_tx", uart_tx, 1);
      chk("rst2_busy", busy, 0);
      chk("rst2_overrun", overrun, 0);
      chk("rst2_level", fifo_level, 0);
      cyc(2);
      reset = 1'b0;
      tape_motor = 1'b0;
      cyc(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/tape_rec_uart.md
Name: tape_rec_uart

Overview:
- Cassette recorder path: the transmit end of the UART tape link whose receive end feeds tape_play.
- Measures the half-period widths of the CPC cassette write signal (tape_rec from Amstrad_motherboard) while the tape motor is on.
- Encodes each width as one byte, buffers the bytes in a FIFO and sends them serially 8N1 on the UART TX pin to the host.
- Sits in the top level between the motherboard tape outputs and UART_TX. It replaces the raw tape_motor-to-UART_TX connection.

Parameters:
- TICK_DIV, 640: clk_sys cycles per measurement unit (64 MHz / 640 = 10 us unit).
- BAUD_DIV, 556: clk_sys cycles per UART bit (about 115200 baud at 64 MHz).
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW = 16 bytes.

Ports:
- clk_sys  in  1  system clock, the only clock
- reset  in  1  synchronous, active-high reset
- tape_out  in  1  cassette write level from the motherboard (tape_rec)
- tape_motor  in  1  cassette motor relay; measurement is enabled only while it is 1
- uart_tx  out  1  serial output, idle high
- busy  out  1  high while the FIFO is non-empty or a frame is in flight
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full
- fifo_level  out  FIFO_AW+1  number of bytes currently stored

Behaviour:
- Reset values: uart_tx=1, busy=0, overrun=0, fifo_level=0. Reset also clears FIFO pointers, all counters and the UART FSM.
- Reset mid-frame: the frame is aborted and uart_tx returns high in the next cycle.
- Input sync: tape_out and tape_motor each pass through 2 flops. The edge detector compares the synchronized value with its 1-cycle delayed copy. Either polarity counts as an edge.
- Prescaler: counts 0..TICK_DIV-1 and asserts tick for one cycle at wrap. It is free-running but cleared whenever motor_s is 0.
- Width counter: 8 bits, incremented on tick.
- Motor off (motor_s=0):
  - Width counter held at 0, armed=0, no pushes.
  - The FIFO and the UART keep draining, so busy can stay high after the motor stops.
- First edge after the motor turns on:
  - Sets armed=1 and clears counter and prescaler.
  - Pushes nothing, because the first half-period is unknown.
- Edge while armed: push max(count,1), then clear counter and prescaler in the same cycle.
- Overflow marker: when armed, the counter is 255 and a tick occurs, push 0x00 and wrap the counter to 0. Host semantics for 0x00: add 2.56 ms with no edge.
- Edge coinciding with the overflow tick: the edge wins. Push 255 only; the counter restarts.
- Push latency: the byte is written into the FIFO on the clock edge after the synchronized edge is detected.
- FIFO: synchronous, 2^FIFO_AW entries.
  - Push and pop in the same cycle are both honoured and fifo_level is unchanged.
  - Push when full with no pop: the byte is dropped and overrun is set to 1. overrun clears only on reset.
  - Pop when empty is impossible; the UART pops only when the level is non-zero.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If fifo_level != 0, pop the head byte into the shift register and go to START.
  - START: uart_tx=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each bit for BAUD_DIV cycles. A 3-bit index selects the bit; after bit 7 go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV cycles, then IDLE.
- Back-to-back frames: IDLE is visible for 1 cycle between frames, so a frame lasts 10*BAUD_DIV+1 cycles.
- busy = (fifo_level != 0) | (state != IDLE).

Test Plan:
- Reset check: hold reset 4 cycles -> uart_tx=1, busy=0, overrun=0, fifo_level=0.
- Basic widths: motor=1; toggle tape_out at t0 (no byte), then after 500 us and 300 us -> UART sends 0x32 then 0x1E (LSB first, start bit 0, stop bit 1, 556 cycles per bit).
- Long gap: motor=1, armed; no edge for 6 ms, then an edge -> bytes 0x00, 0x00, then 0x58 (remaining 880 us). Checks overflow wrap and saturation rules.
- Short pulse: two edges 3 us apart while armed -> byte 0x01, the clamped minimum.
- Motor gating: motor=0; toggle tape_out 10 times -> no bytes and busy stays 0. Motor off while 3 bytes are queued -> all 3 are still transmitted, then busy falls.
- Overrun and reset: BAUD_DIV held large, 20 edges at 50 us -> first byte popped to UART, fifo_level=16, overrun=1. Asserting reset mid-frame -> uart_tx=1 next cycle and all outputs at reset values.
